telem_packet_serializer: RTL and testbench

TELEM_PACKET_SERIALIZER -- requirements
Module: telem_packet_serializer

---
 rtl/telem_packet_serializer.sv | 188 ++++++++++++++++++
 tb/tb_telem_packet_serializer.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/telem_packet_serializer.sv
// Telemetry packet serializer: buffers wide packets in a small FIFO and emits them
// as registered words, least-significant slice first, with optional trailer words.
module telem_packet_serializer #(
    parameter int unsigned           PKT_WIDTH  = 88,
    parameter int unsigned           WORD_WIDTH = 16,
    parameter int unsigned           FIFO_DEPTH = 4,
    parameter bit                    TRAILER_EN = 1'b1,
    parameter logic [WORD_WIDTH-1:0] TRAILER0   = 16'hF00D,
    parameter logic [WORD_WIDTH-1:0] TRAILER1   = 16'hC0DE,
    parameter logic [WORD_WIDTH-1:0] PAD_VALUE  = 16'h7C00
) (
    input  logic                    clk_128M,
    input  logic                    rst_128M,
    input  logic                    pkt_valid,
    input  logic [PKT_WIDTH-1:0]    pkt_data,
    output logic [WORD_WIDTH-1:0]   out_data,
    output logic [WORD_WIDTH/8-1:0] out_be,
    output logic                    out_valid,
    input  logic                    out_full,
    input  logic                    clear_counters,
    output logic [15:0]             pkt_count,
    output logic [15:0]             drop_count,
    output logic                    busy
);

    localparam int unsigned NW    = (PKT_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int unsigned EXT_W = NW * WORD_WIDTH;
    localparam int unsigned IDX_W = (NW > 1) ? $clog2(NW) : 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned BE_W  = WORD_WIDTH / 8;

    localparam logic [PTR_W:0]   DEPTH_L  = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NW - 1);

    // Bits above PKT_WIDTH take the same bit positions of PAD_VALUE within their word.
    function automatic logic [EXT_W-1:0] pad_ext();
        logic [EXT_W-1:0] v;
        v = '0;
        for (int i = PKT_WIDTH; i < EXT_W; i++) begin
            v[i] = PAD_VALUE[i % WORD_WIDTH];
        end
        return v;
    endfunction

    localparam logic [EXT_W-1:0] PAD_EXT = pad_ext();

    function automatic logic [WORD_WIDTH-1:0] word_of(input logic [EXT_W-1:0] ext,
                                                      input logic [IDX_W-1:0] idx);
        logic [WORD_WIDTH-1:0] w;
        w = '0;
        for (int i = 0; i < NW; i++) begin
            if (idx == IDX_W'(i)) w = ext[i*WORD_WIDTH +: WORD_WIDTH];
        end
        return w;
    endfunction

    typedef enum logic [1:0] {StIdle, StData, StTrailer} state_e;

    state_e                  state_q, state_d;
    logic [PKT_WIDTH-1:0]    mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]          count_q, count_d;
    logic [EXT_W-1:0]        cur_q, cur_d, head_ext;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    tsel_q, tsel_d;
    logic [WORD_WIDTH-1:0]   out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic [BE_W-1:0]         out_be_q;
    logic [15:0]             pkt_cnt_q, drop_cnt_q;
    logic                    push, drop, pop, pkt_end;

    // Full/drop decision uses pre-edge occupancy, independent of a same-cycle pop.
    assign push     = pkt_valid && (count_q != DEPTH_L);
    assign drop     = pkt_valid && (count_q == DEPTH_L);
    assign head_ext = EXT_W'(mem_q[rd_ptr_q]) | PAD_EXT;

    always_ff @(posedge clk_128M) begin
        if (push) mem_q[wr_ptr_q] <= pkt_data;
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        idx_d       = idx_q;
        tsel_d      = tsel_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        pop         = 1'b0;
        pkt_end     = 1'b0;
        // Nothing moves while downstream is full, so the output word holds.
        if (!out_full) begin
            unique case (state_q)
                StIdle: pkt_end = 1'b1;
                StData: begin
                    if (idx_q == IDX_LAST) begin
                        if (TRAILER_EN) begin
                            state_d    = StTrailer;
                            tsel_d     = 1'b0;
                            out_data_d = TRAILER0;
                        end else begin
                            pkt_end = 1'b1;
                        end
                    end else begin
                        idx_d      = idx_q + 1'b1;
                        out_data_d = word_of(cur_q, idx_q + 1'b1);
                    end
                end
                StTrailer: begin
                    if (!tsel_q) begin
                        tsel_d     = 1'b1;
                        out_data_d = TRAILER1;
                    end else begin
                        pkt_end = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
            if (pkt_end) begin
                if (count_q == '0) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b0;
                    out_data_d  = '0;
                end else begin
                    pop         = 1'b1;
                    cur_d       = head_ext;
                    idx_d       = '0;
                    state_d     = StData;
                    out_valid_d = 1'b1;
                    out_data_d  = head_ext[WORD_WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk_128M or posedge rst_128M) begin
        if (rst_128M) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cur_q       <= '0;
            idx_q       <= '0;
            tsel_q      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_be_q    <= '0;
        end else begin
            state_q     <= state_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q     <= count_d;
            cur_q       <= cur_d;
            idx_q       <= idx_d;
            tsel_q      <= tsel_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_be_q    <= out_valid_d ? {BE_W{1'b1}} : '0;
        end
    end

    // Clear wins over a same-cycle increment; counters stick at all-ones.
    always_ff @(posedge clk_128M or posedge rst_128M) begin
        if (rst_128M) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else if (clear_counters) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (push && pkt_cnt_q != 16'hFFFF)  pkt_cnt_q  <= pkt_cnt_q + 16'd1;
            if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_be     = out_be_q;
    assign pkt_count  = pkt_cnt_q;
    assign drop_count = drop_cnt_q;
    assign busy       = (state_q != StIdle) || (count_q != '0);

endmodule

// File: tb/tb_telem_packet_serializer.sv
// Scoreboard bench: default-parameter serializer plus a 32-bit, trailer-less instance.
module tb_telem_packet_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        pkt_valid_a = 1'b0;
    logic [87:0] pkt_data_a = '0;
    logic [15:0] out_data_a;
    logic [1:0]  out_be_a;
    logic        out_valid_a;
    logic        out_full_a = 1'b0;
    logic        clear_a = 1'b0;
    logic [15:0] pkt_count_a, drop_count_a;
    logic        busy_a;

    logic        pkt_valid_b = 1'b0;
    logic [31:0] pkt_data_b = '0;
    logic [15:0] out_data_b;
    logic [1:0]  out_be_b;
    logic        out_valid_b;
    logic        out_full_b = 1'b0;
    logic        clear_b = 1'b0;
    logic [15:0] pkt_count_b, drop_count_b;
    logic        busy_b;

    int checks = 0;
    int errors = 0;
    logic [15:0] qa[$];
    logic [15:0] qb[$];

    always #5 clk = ~clk;

    telem_packet_serializer dut_a (
        .clk_128M(clk), .rst_128M(rst), .pkt_valid(pkt_valid_a), .pkt_data(pkt_data_a),
        .out_data(out_data_a), .out_be(out_be_a), .out_valid(out_valid_a),
        .out_full(out_full_a), .clear_counters(clear_a), .pkt_count(pkt_count_a),
        .drop_count(drop_count_a), .busy(busy_a)
    );

    telem_packet_serializer #(.PKT_WIDTH(32), .WORD_WIDTH(16), .TRAILER_EN(1'b0)) dut_b (
        .clk_128M(clk), .rst_128M(rst), .pkt_valid(pkt_valid_b), .pkt_data(pkt_data_b),
        .out_data(out_data_b), .out_be(out_be_b), .out_valid(out_valid_b),
        .out_full(out_full_b), .clear_counters(clear_b), .pkt_count(pkt_count_b),
        .drop_count(drop_count_b), .busy(busy_b)
    );

    function automatic logic [15:0] word_a(input logic [87:0] p, input int i);
        logic [95:0] ext;
        ext = {8'h7C, p};
        return ext[i*16 +: 16];
    endfunction

    task automatic expect_pkt_a(input logic [87:0] p);
        for (int i = 0; i < 6; i++) qa.push_back(word_a(p, i));
        qa.push_back(16'hF00D);
        qa.push_back(16'hC0DE);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: a word is consumed on every edge where valid is high and full is low.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid_a && !out_full_a) begin
                logic [15:0] e;
                checks++;
                if (qa.size() == 0) begin
                    errors++;
                    $display("FAIL word_a unexpected got %h expected none", out_data_a);
                end else begin
                    e = qa.pop_front();
                    if (out_data_a !== e) begin
                        errors++;
                        $display("FAIL word_a got %h expected %h", out_data_a, e);
                    end
                end
                checks++;
                if (out_be_a !== 2'b11) begin
                    errors++;
                    $display("FAIL be_a got %b expected 11", out_be_a);
                end
            end
            if (!out_valid_a && out_data_a !== 16'h0) begin
                checks++;
                errors++;
                $display("FAIL idle_data_a got %h expected 0000", out_data_a);
            end
            if (out_valid_b && !out_full_b) begin
                logic [15:0] e;
                checks++;
                if (qb.size() == 0) begin
                    errors++;
                    $display("FAIL word_b unexpected got %h expected none", out_data_b);
                end else begin
                    e = qb.pop_front();
                    if (out_data_b !== e) begin
                        errors++;
                        $display("FAIL word_b got %h expected %h", out_data_b, e);
                    end
                end
            end
        end
    end

    task automatic wait_drain(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (qa.size() == 0 && qb.size() == 0 && !busy_a && !busy_b && !out_valid_a
                && !out_valid_b) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain got %0d/%0d pending expected 0", qa.size(), qb.size());
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({out_valid_a, out_data_a, out_be_a, busy_a} !== 20'h0) begin
            errors++;
            $display("FAIL reset_out got %b%h%b%b expected 0", out_valid_a, out_data_a,
                     out_be_a, busy_a);
        end
        checks++;
        if ({pkt_count_a, drop_count_a} !== 32'h0) begin
            errors++;
            $display("FAIL reset_cnt got %h %h expected 0 0", pkt_count_a, drop_count_a);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int first = -1;
        int nvalid = 0;
        pkt_valid_a = 1'b1;
        pkt_data_a = 88'h0A_9988_7766_5544_3322_1100;
        expect_pkt_a(pkt_data_a);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid_a) begin
                if (first < 0) first = k;
                nvalid++;
            end
            if (k == 0) begin
                tick();
                pkt_valid_a = 1'b0;
            end
        end
        checks++;
        if (first != 2) begin
            errors++;
            $display("FAIL latency got %0d expected 2", first);
        end
        checks++;
        if (nvalid != 8) begin
            errors++;
            $display("FAIL single_len got %0d expected 8", nvalid);
        end
        checks++;
        if (pkt_count_a !== 16'd1) begin
            errors++;
            $display("FAIL single_pkt_count got %0d expected 1", pkt_count_a);
        end
        wait_drain(50);
    endtask

    task automatic test_backpressure();
        logic [87:0] p;
        logic [15:0] w2;
        p = 88'h55_AAAA_BBBB_CCCC_DDDD_EEEE;
        w2 = word_a(p, 2);
        pkt_valid_a = 1'b1;
        pkt_data_a = p;
        expect_pkt_a(p);
        tick();
        pkt_valid_a = 1'b0;
        repeat (3) tick();
        checks++;
        if (out_data_a !== w2) begin
            errors++;
            $display("FAIL bp_word2 got %h expected %h", out_data_a, w2);
        end
        out_full_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (!out_valid_a || out_data_a !== w2) begin
                errors++;
                $display("FAIL bp_hold got %b %h expected 1 %h", out_valid_a, out_data_a, w2);
            end
            tick();
        end
        out_full_a = 1'b0;
        wait_drain(50);
    endtask

    task automatic test_overflow();
        int nvalid = 0;
        clear_a = 1'b1;
        tick();
        clear_a = 1'b0;
        out_full_a = 1'b1;
        for (int i = 0; i < 6; i++) begin
            pkt_valid_a = 1'b1;
            pkt_data_a = {$urandom, $urandom, $urandom};
            if (i < 4) expect_pkt_a(pkt_data_a);
            tick();
        end
        pkt_valid_a = 1'b0;
        checks++;
        if (pkt_count_a !== 16'd4 || drop_count_a !== 16'd2) begin
            errors++;
            $display("FAIL ovf_counts got %0d %0d expected 4 2", pkt_count_a, drop_count_a);
        end
        out_full_a = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (out_valid_a) nvalid++;
        end
        @(negedge clk);
        checks++;
        if (nvalid != 32 || out_valid_a) begin
            errors++;
            $display("FAIL ovf_contig got %0d tail %b expected 32 0", nvalid, out_valid_a);
        end
        wait_drain(50);
    endtask

    task automatic test_no_trailer();
        int nvalid = 0;
        pkt_valid_b = 1'b1;
        pkt_data_b = 32'h1234_5678;
        qb.push_back(16'h5678);
        qb.push_back(16'h1234);
        tick();
        pkt_data_b = 32'hDEAD_BEEF;
        qb.push_back(16'hBEEF);
        qb.push_back(16'hDEAD);
        tick();
        pkt_valid_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid_b) nvalid++;
        end
        checks++;
        if (nvalid != 4) begin
            errors++;
            $display("FAIL notrl_len got %0d expected 4", nvalid);
        end
        wait_drain(50);
    endtask

    task automatic test_reset_mid();
        logic [87:0] p;
        p = 88'h3C_0F0F_1E1E_2D2D_4B4B_5A5A;
        pkt_valid_a = 1'b1;
        pkt_data_a = p;
        expect_pkt_a(p);
        tick();
        pkt_valid_a = 1'b0;
        repeat (4) tick();
        checks++;
        if (out_data_a !== word_a(p, 3)) begin
            errors++;
            $display("FAIL mid_word3 got %h expected %h", out_data_a, word_a(p, 3));
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid_a, out_data_a, out_be_a, busy_a, pkt_count_a} !== 36'h0) begin
            errors++;
            $display("FAIL mid_reset got %b %h %b %b %0d expected all 0", out_valid_a,
                     out_data_a, out_be_a, busy_a, pkt_count_a);
        end
        qa.delete();
        pkt_valid_a = 1'b1;
        tick();
        tick();
        pkt_valid_a = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid_a || busy_a) begin
                errors++;
                $display("FAIL post_reset_idle got %b %b expected 0 0", out_valid_a, busy_a);
            end
        end
        tick();
        p = 88'h21_1357_2468_9BDF_ACE0_F00F;
        pkt_valid_a = 1'b1;
        pkt_data_a = p;
        expect_pkt_a(p);
        tick();
        pkt_valid_a = 1'b0;
        wait_drain(50);
        checks++;
        if (pkt_count_a !== 16'd1) begin
            errors++;
            $display("FAIL post_reset_cnt got %0d expected 1", pkt_count_a);
        end
    endtask

    task automatic test_drop_saturate();
        clear_a = 1'b1;
        tick();
        clear_a = 1'b0;
        out_full_a = 1'b1;
        pkt_valid_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pkt_data_a = {$urandom, $urandom, $urandom};
            expect_pkt_a(pkt_data_a);
            tick();
        end
        pkt_data_a = '1;
        repeat (65537) tick();
        checks++;
        if (drop_count_a !== 16'hFFFF || pkt_count_a !== 16'd4) begin
            errors++;
            $display("FAIL sat got %h %0d expected ffff 4", drop_count_a, pkt_count_a);
        end
        clear_a = 1'b1;
        tick();
        clear_a = 1'b0;
        pkt_valid_a = 1'b0;
        checks++;
        if (drop_count_a !== 16'h0 || pkt_count_a !== 16'h0) begin
            errors++;
            $display("FAIL clear_prio got %h %h expected 0 0", drop_count_a, pkt_count_a);
        end
        tick();
        checks++;
        if (drop_count_a !== 16'h0) begin
            errors++;
            $display("FAIL clear_hold got %h expected 0", drop_count_a);
        end
        out_full_a = 1'b0;
        wait_drain(100);
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_no_trailer();
        test_reset_mid();
        test_drop_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
